rah_sha_stream_bridge: RTL and testbench
========================================

# rah_sha_stream_bridge

Parametrised successor to the miner-side SHA bridge. It drains fixed-width words from the host write FIFO and assembles a block header of arbitrary width, then hands the header to the double-SHA miner with a one-cycle `input_valid` strobe. It captures the miner's hash output and serialises it, under backpressure, into the post-processing FIFO. A watchdog aborts a stalled transaction and flags it.

## Interface
- `WORD_W`, 48: FIFO word width, in both directions.
- `HDR_W`, 512: block header width.
- `HASH_W`, 256: width of each hash output.
- `WDT_LIMIT`, 5000000: stall cycles before abort. Must be ≥2.
- Derived: `HDR_WORDS = ceil(HDR_W/WORD_W)` (11 at defaults) and `HASH_WORDS = ceil(HASH_W/WORD_W)` (6 at defaults).
- `clk`  in  1  sole clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_fifo_empty`  in  1  write FIFO empty.
- `wr_fifo_read_data`  in  WORD_W  write FIFO data, valid the cycle after `wr_fifo_read_en`.
- `wr_fifo_read_en`  out  1  write FIFO pop.
- `block_header`  out  HDR_W  assembled header.
- `input_valid`  out  1  one-cycle header strobe to the miner.
- `output_valid`  in  1  miner result strobe.
- `hash1_out`  in  HASH_W  first-pass hash.
- `hash_result`  in  HASH_W  final hash.
- `pp_fifo_full`  in  1  post-processing FIFO full.
- `pp_fifo_wr_en`  out  1  post-processing FIFO push.
- `pp_fifo_wr_data`  out  WORD_W  post-processing FIFO data.
- `wdt_abort`  out  1  one-cycle pulse on watchdog abort.
- `abort_count`  out  8  saturating count of aborts.

## Operation
- FSM states: COLLECT, ISSUE, WAIT, DRAIN. Reset enters COLLECT.

**COLLECT**
- `wr_fifo_read_en` is registered.
- It is asserted when `!wr_fifo_empty` and fewer than `HDR_WORDS` reads have been issued. The block never over-reads.
- A captured word shifts in from the LSB: `hdr <= {hdr[HDR_W-WORD_W-1:0], data}`.
- The first word read therefore ends up at the MSB end. Its upper `HDR_WORDS*WORD_W-HDR_W` bits (16 at defaults) are discarded.
- On the `HDR_WORDS`th capture the FSM goes to ISSUE, and both the issued and captured counters clear.

**ISSUE**
- `input_valid` = 1 for exactly one cycle, then the FSM goes to WAIT.

**WAIT**
- On `output_valid`, latch `hash1_out` (and `hash_result`, see Configuration) into a holding register and go to DRAIN.
- `output_valid` in any other state is ignored.

**DRAIN**
- Emits the first-pass hash as `HASH_WORDS` words, MSB chunk first.
- At defaults the order is `{32'b0, h[255:240]}`, then `h[239:192]` … `h[47:0]`. The MSB chunk is zero-extended.
- `pp_fifo_wr_en = (state==DRAIN) && !pp_fifo_full` (combinational on full). The word index advances only on an accepted push.
- After the last accepted word the FSM returns to COLLECT.

**Watchdog**
- The counter increments each cycle the FSM is in COLLECT with ≥1 read issued, or in ISSUE or WAIT. Otherwise it clears. DRAIN stalls never count.
- When the count reaches `WDT_LIMIT`:
  - `wdt_abort` pulses.
  - `abort_count` increments, saturating at 255.
  - The counters clear and the FSM goes to COLLECT.
- A FIFO word arriving the cycle after the abort is dropped, not captured.
- The counter width is `$clog2(WDT_LIMIT+1)`.

## Timing
- Reset values: all outputs 0. `block_header` = 0, `abort_count` = 0, FSM in COLLECT.
- FIFO read latency is 1: data for the pop at edge N is captured at edge N+1. Back-to-back pops give one word per cycle.
- Best-case header latency, from the first `wr_fifo_read_en` to `input_valid`, is `HDR_WORDS+1` cycles.
- `block_header` holds stable from ISSUE until the next header's first capture.
- From `output_valid` to the first `pp_fifo_wr_en` is 1 cycle when the FIFO is not full.
- In DRAIN, `pp_fifo_wr_data` holds while `pp_fifo_full` is high.
- An abort and a final capture on the same edge: the abort wins.
- An abort and `output_valid` on the same edge: the abort wins.
- `rst_n` low mid-transaction: everything clears immediately. Partial headers are lost, and no `input_valid` is emitted.

## Configuration
- `RAH_BRIDGE_FINAL_HASH_EN` defined:
  - The holding register also latches `hash_result`.
  - DRAIN emits `2*HASH_WORDS` words: all `hash1_out` words first, then `hash_result` in the same chunk order.
- Undefined:
  - DRAIN emits `HASH_WORDS` words of `hash1_out` only.
  - `hash_result` is unused and not registered.

## Test plan
- **Header assembly.** Defaults; preload 11 words with `0x0000_0000_0001` … `0x0000_0000_000B`.
  - `block_header[47:0]` = `0xB`, `[511:480]` = `0x1`.
  - One `input_valid` pulse, exactly 11 pops.
- **Stalled header.** FIFO empties after 5 words and `WDT_LIMIT`=100.
  - `wdt_abort` pulses 100 cycles after the first pop.
  - `abort_count`=1, FSM in COLLECT, no `input_valid`.
- **Hash drain.** `hash1_out = 256'h0123…CDEF`, `output_valid` asserted for 1 cycle in WAIT.
  - 6 pushes, first `{32'b0, 16'h0123}`, last = `hash1_out[47:0]`.
- **Backpressure.** `pp_fifo_full` high for 10 cycles mid-drain.
  - Data held, no extra or lost words, no `wdt_abort`.
- **Final hash.** With `RAH_BRIDGE_FINAL_HASH_EN`: 12 pushes, words 7–12 = `hash_result` chunks.
- **Reset mid-transaction.** `rst_n` low after 4 captures, then 11 new words.
  - The header contains only the new words.
  - Exactly one `input_valid`.

Source files
------------

// File: rtl/rah_sha_stream_bridge.sv
// Host-FIFO to double-SHA miner bridge: assembles block headers, strobes the miner and serialises
// hash results into the post-processing FIFO. Define RAH_BRIDGE_FINAL_HASH_EN to also drain hash_result.
//
// state   | meaning
// COLLECT | popping host words and shifting them into the header
// ISSUE   | one-cycle input_valid strobe to the miner
// WAIT    | waiting for the miner's output_valid
// DRAIN   | pushing held hash words to the post-processing FIFO
module rah_sha_stream_bridge #(
    parameter int WORD_W    = 48,
    parameter int HDR_W     = 512,
    parameter int HASH_W    = 256,
    parameter int WDT_LIMIT = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_fifo_empty,
    input  logic [WORD_W-1:0] wr_fifo_read_data,
    output logic              wr_fifo_read_en,
    output logic [HDR_W-1:0]  block_header,
    output logic              input_valid,
    input  logic              output_valid,
    input  logic [HASH_W-1:0] hash1_out,
    input  logic [HASH_W-1:0] hash_result,
    input  logic              pp_fifo_full,
    output logic              pp_fifo_wr_en,
    output logic [WORD_W-1:0] pp_fifo_wr_data,
    output logic              wdt_abort,
    output logic [7:0]        abort_count
);
    localparam int HDR_WORDS  = (HDR_W + WORD_W - 1) / WORD_W;
    localparam int HASH_WORDS = (HASH_W + WORD_W - 1) / WORD_W;
    localparam int HASH_PAD   = HASH_WORDS * WORD_W;
`ifdef RAH_BRIDGE_FINAL_HASH_EN
    localparam int DRAIN_WORDS = 2 * HASH_WORDS;
`else
    localparam int DRAIN_WORDS = HASH_WORDS;
`endif
    localparam int HOLD_W = DRAIN_WORDS * WORD_W;
    localparam int CNT_W  = $clog2(HDR_WORDS + 1);
    localparam int IDX_W  = $clog2(DRAIN_WORDS + 1);
    localparam int WDT_W  = $clog2(WDT_LIMIT + 1);

    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  issued, issued_nxt, captured;
    logic              cap_pend;
    logic [HDR_W-1:0]  hdr;
    logic [HOLD_W-1:0] hold;
    logic [IDX_W-1:0]  widx;
    logic [WDT_W-1:0]  wdt_cnt;
    logic              pop_ok, last_cap, push, last_push, wdt_inc, wdt_fire;

`ifndef RAH_BRIDGE_FINAL_HASH_EN
    logic unused_hash;
    assign unused_hash = ^hash_result;
`endif

    // A pop only counts when the FIFO actually had a word at that edge.
    assign pop_ok     = wr_fifo_read_en && !wr_fifo_empty;
    assign issued_nxt = issued + CNT_W'(pop_ok);
    assign last_cap   = cap_pend && (captured == CNT_W'(HDR_WORDS - 1));
    assign push       = (state == DRAIN) && !pp_fifo_full;
    assign last_push  = push && (widx == IDX_W'(DRAIN_WORDS - 1));
    assign wdt_inc    = ((state == COLLECT) && ((issued != '0) || wr_fifo_read_en))
                        || (state == ISSUE) || (state == WAIT);
    assign wdt_fire   = wdt_inc && (wdt_cnt == WDT_W'(WDT_LIMIT - 1));

    assign input_valid     = (state == ISSUE);
    assign pp_fifo_wr_en   = push;
    assign pp_fifo_wr_data = hold[HOLD_W-1 -: WORD_W];
    assign block_header    = hdr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_cap) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (output_valid) state_nxt = DRAIN;
            DRAIN:   if (last_push) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
        if (wdt_fire) state_nxt = COLLECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_fifo_read_en <= 1'b0;
            issued          <= '0;
            captured        <= '0;
            cap_pend        <= 1'b0;
            hdr             <= '0;
            hold            <= '0;
            widx            <= '0;
            wdt_cnt         <= '0;
            wdt_abort       <= 1'b0;
            abort_count     <= 8'd0;
        end else begin
            wdt_abort <= wdt_fire;
            if (wdt_fire) begin
                // Abort drops any word still in flight from the last pop.
                wr_fifo_read_en <= 1'b0;
                issued          <= '0;
                captured        <= '0;
                cap_pend        <= 1'b0;
                wdt_cnt         <= '0;
                if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
            end else begin
                wdt_cnt         <= wdt_inc ? wdt_cnt + WDT_W'(1) : '0;
                cap_pend        <= pop_ok;
                wr_fifo_read_en <= (state == COLLECT) && !wr_fifo_empty
                                   && (issued_nxt < CNT_W'(HDR_WORDS));
                issued          <= last_cap ? '0 : issued_nxt;
                if (cap_pend) begin
                    hdr      <= {hdr[HDR_W-WORD_W-1:0], wr_fifo_read_data};
                    captured <= last_cap ? '0 : captured + CNT_W'(1);
                end
                if ((state == WAIT) && output_valid) begin
`ifdef RAH_BRIDGE_FINAL_HASH_EN
                    hold <= {HASH_PAD'(hash1_out), HASH_PAD'(hash_result)};
`else
                    hold <= HASH_PAD'(hash1_out);
`endif
                    widx <= '0;
                end else if (push) begin
                    hold <= hold << WORD_W;
                    widx <= last_push ? '0 : widx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_rah_sha_stream_bridge.sv
// Bench for rah_sha_stream_bridge: FIFO and miner models around the DUT, with header and
// hash-word expectations computed from plain concatenation/chunking rules.
module tb_rah_sha_stream_bridge;
    localparam int WORD_W     = 48;
    localparam int HDR_W      = 512;
    localparam int HASH_W     = 256;
    localparam int WDT_LIMIT  = 100;
    localparam int HDR_WORDS  = 11;
    localparam int HASH_WORDS = 6;
    localparam int HASH_PAD   = HASH_WORDS * WORD_W;
`ifdef RAH_BRIDGE_FINAL_HASH_EN
    localparam int DRAIN_WORDS = 2 * HASH_WORDS;
`else
    localparam int DRAIN_WORDS = HASH_WORDS;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_fifo_empty;
    logic [WORD_W-1:0] wr_fifo_read_data = '0;
    logic              wr_fifo_read_en;
    logic [HDR_W-1:0]  block_header;
    logic              input_valid;
    logic              output_valid;
    logic [HASH_W-1:0] hash1_out;
    logic [HASH_W-1:0] hash_result;
    logic              pp_fifo_full;
    logic              pp_fifo_wr_en;
    logic [WORD_W-1:0] pp_fifo_wr_data;
    logic              wdt_abort;
    logic [7:0]        abort_count;

    rah_sha_stream_bridge #(
        .WORD_W(WORD_W), .HDR_W(HDR_W), .HASH_W(HASH_W), .WDT_LIMIT(WDT_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_fifo_empty(wr_fifo_empty), .wr_fifo_read_data(wr_fifo_read_data),
        .wr_fifo_read_en(wr_fifo_read_en), .block_header(block_header),
        .input_valid(input_valid), .output_valid(output_valid),
        .hash1_out(hash1_out), .hash_result(hash_result),
        .pp_fifo_full(pp_fifo_full), .pp_fifo_wr_en(pp_fifo_wr_en),
        .pp_fifo_wr_data(pp_fifo_wr_data), .wdt_abort(wdt_abort), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Host write FIFO: words written by the stimulus, popped with one cycle of read latency.
    logic [WORD_W-1:0] stim_mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign wr_fifo_empty = (rd_ptr == wr_ptr);

    initial begin : fifo_model
        bit do_pop;
        forever begin
            @(posedge clk);
            do_pop = wr_fifo_read_en && !wr_fifo_empty;
            #1;
            if (!rst_n) rd_ptr = wr_ptr;
            else if (do_pop) begin
                wr_fifo_read_data = stim_mem[rd_ptr];
                rd_ptr = rd_ptr + 1;
            end else wr_fifo_read_data = WORD_W'({$urandom(), $urandom()});
        end
    end

    int iv_count = 0;
    int ab_count = 0;
    logic [WORD_W-1:0] push_q[$];
    initial forever begin
        @(negedge clk);
        #2;
        if (input_valid) iv_count = iv_count + 1;
        if (wdt_abort) ab_count = ab_count + 1;
        if (pp_fifo_wr_en) push_q.push_back(pp_fifo_wr_data);
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        stim_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // which: 0 = wr_fifo_read_en, 1 = input_valid, 2 = wdt_abort
    task automatic wait_for(input int which, input int budget, input string tag, output int at_cyc);
        bit found = 0;
        at_cyc = -1;
        for (int i = 0; i < budget && !found; i++) begin
            if ((which == 0 && wr_fifo_read_en) || (which == 1 && input_valid)
                || (which == 2 && wdt_abort)) begin
                found = 1;
                at_cyc = cyc;
            end else tick();
        end
        check({tag, "_seen"}, 512'(found), 512'(1));
    endtask

    task automatic wait_pushes(input int n, input int budget);
        for (int i = 0; i < budget && push_q.size() < n; i++) tick();
    endtask

    function automatic logic [HDR_W-1:0] model_hdr(input logic [WORD_W-1:0] w [HDR_WORDS]);
        logic [HDR_WORDS*WORD_W-1:0] acc;
        for (int i = 0; i < HDR_WORDS; i++) acc[(HDR_WORDS-1-i)*WORD_W +: WORD_W] = w[i];
        return acc[HDR_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] model_word(input logic [HASH_W-1:0] h1,
                                                     input logic [HASH_W-1:0] hr, input int i);
        logic [HASH_PAD-1:0] p;
        int k;
        p = (i < HASH_WORDS) ? HASH_PAD'(h1) : HASH_PAD'(hr);
        k = i % HASH_WORDS;
        return p[(HASH_WORDS-1-k)*WORD_W +: WORD_W];
    endfunction

    // One complete transaction: header in, miner result, drain with an optional 10-cycle stall.
    task automatic run_txn(input logic [WORD_W-1:0] w [HDR_WORDS], input int gap_at, input int gap_len,
                           input logic [HASH_W-1:0] h1, input logic [HASH_W-1:0] hr,
                           input int stall_at, input string tag);
        int p0, iv0, t0, t1, n0, ab0;
        logic [WORD_W-1:0] held;
        p0  = wr_ptr;
        iv0 = iv_count;
        for (int i = 0; i < HDR_WORDS; i++) begin
            push_word(w[i]);
            if (i == gap_at) repeat (gap_len) tick();
        end
        wait_for(0, 20, {tag, "_rd_en"}, t0);
        wait_for(1, 80, {tag, "_input_valid"}, t1);
        if (gap_at < 0) check({tag, "_hdr_latency"}, 512'(t1 - t0), 512'(HDR_WORDS + 1));
        check({tag, "_header"}, 512'(block_header), 512'(model_hdr(w)));
        check({tag, "_pops"}, 512'(rd_ptr - p0), 512'(HDR_WORDS));

        tick();
        repeat ($urandom_range(0, 3)) tick();
        n0  = push_q.size();
        ab0 = ab_count;
        hash1_out    = h1;
        hash_result  = hr;
        output_valid = 1'b1;
        tick();
        output_valid = 1'b0;
        hash1_out    = HASH_W'({8{$urandom()}});
        hash_result  = HASH_W'({8{$urandom()}});
        check({tag, "_first_push_latency"}, 512'(pp_fifo_wr_en), 512'(1));
        if (stall_at > 0) begin
            wait_pushes(n0 + stall_at, 40);
            pp_fifo_full = 1'b1;
            held = pp_fifo_wr_data;
            repeat (10) tick();
            check({tag, "_stall_data_held"}, 512'(pp_fifo_wr_data), 512'(held));
            check({tag, "_stall_no_push"}, 512'(push_q.size()), 512'(n0 + stall_at));
            pp_fifo_full = 1'b0;
        end
        wait_pushes(n0 + DRAIN_WORDS, 60);
        repeat (3) tick();
        check({tag, "_push_count"}, 512'(push_q.size()), 512'(n0 + DRAIN_WORDS));
        for (int i = 0; i < DRAIN_WORDS; i++)
            check($sformatf("%s_word%0d", tag, i), 512'(push_q[n0 + i]), 512'(model_word(h1, hr, i)));
        check({tag, "_no_abort"}, 512'(ab_count), 512'(ab0));
        check({tag, "_one_input_valid"}, 512'(iv_count), 512'(iv0 + 1));
    endtask

    initial begin
        logic [WORD_W-1:0] w [HDR_WORDS];
        logic [HASH_W-1:0] h1, hr;
        int base, p0, iv0, t0, t1, gap;

        rst_n        = 1'b0;
        output_valid = 1'b0;
        hash1_out    = '0;
        hash_result  = '0;
        pp_fifo_full = 1'b0;
        tick();
        tick();
        check("rst_rd_en", 512'(wr_fifo_read_en), 512'(0));
        check("rst_input_valid", 512'(input_valid), 512'(0));
        check("rst_block_header", 512'(block_header), 512'(0));
        check("rst_pp_wr_en", 512'(pp_fifo_wr_en), 512'(0));
        check("rst_pp_wr_data", 512'(pp_fifo_wr_data), 512'(0));
        check("rst_wdt_abort", 512'(wdt_abort), 512'(0));
        check("rst_abort_count", 512'(abort_count), 512'(0));
        rst_n = 1'b1;
        tick();

        // Directed header 1..11 with the reference hash pattern.
        for (int i = 0; i < HDR_WORDS; i++) w[i] = WORD_W'(i + 1);
        h1 = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
        hr = HASH_W'({8{$urandom()}});
        base = push_q.size();
        run_txn(w, -1, 0, h1, hr, 0, "directed");
        check("directed_hdr_lsb", 512'(block_header[47:0]), 512'(48'hB));
        check("directed_hdr_msb", 512'(block_header[511:480]), 512'(32'h1));
        check("directed_first_word", 512'(push_q[base]), 512'(48'h0000_0000_0123));
        check("directed_last_h1_word", 512'(push_q[base + HASH_WORDS - 1]), 512'(h1[47:0]));

        // output_valid outside WAIT must not start a drain.
        base = push_q.size();
        output_valid = 1'b1;
        hash1_out = HASH_W'({8{$urandom()}});
        tick();
        output_valid = 1'b0;
        repeat (3) tick();
        check("ignored_output_valid", 512'(push_q.size()), 512'(base));

        // Random headers, some with input gaps, with backpressure mid-drain.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < HDR_WORDS; i++) w[i] = WORD_W'({$urandom(), $urandom()});
            h1  = HASH_W'({8{$urandom()}});
            hr  = HASH_W'({8{$urandom()}});
            gap = (k == 0) ? -1 : int'($urandom_range(0, 9));
            run_txn(w, gap, int'($urandom_range(1, 8)), h1, hr, int'($urandom_range(1, 5)),
                    $sformatf("rand%0d", k));
        end

        // Stalled header: only 5 words ever arrive.
        p0  = wr_ptr;
        iv0 = iv_count;
        for (int i = 0; i < 5; i++) push_word(WORD_W'({$urandom(), $urandom()}));
        wait_for(0, 20, "stall_rd_en", t0);
        wait_for(2, 150, "stall_abort", t1);
        check("stall_abort_timing", 512'(t1 - t0), 512'(WDT_LIMIT));
        tick();
        check("stall_abort_count", 512'(abort_count), 512'(1));
        check("stall_abort_pulse_width", 512'(wdt_abort), 512'(0));
        check("stall_no_input_valid", 512'(iv_count), 512'(iv0));
        check("stall_pops", 512'(rd_ptr - p0), 512'(5));

        for (int i = 0; i < HDR_WORDS; i++) w[i] = WORD_W'({$urandom(), $urandom()});
        run_txn(w, -1, 0, HASH_W'({8{$urandom()}}), HASH_W'({8{$urandom()}}), 2, "post_abort");

        // Reset in the middle of a header.
        for (int i = 0; i < HDR_WORDS; i++) push_word(WORD_W'({$urandom(), $urandom()}));
        wait_for(0, 20, "rstmid_rd_en", t0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_header_cleared", 512'(block_header), 512'(0));
        check("rstmid_rd_en_cleared", 512'(wr_fifo_read_en), 512'(0));
        check("rstmid_abort_count_cleared", 512'(abort_count), 512'(0));
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < HDR_WORDS; i++) w[i] = WORD_W'({$urandom(), $urandom()});
        run_txn(w, -1, 0, HASH_W'({8{$urandom()}}), HASH_W'({8{$urandom()}}), 0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed time %0t required finish before it", $time);
        $fatal(1, "bench timeout");
    end
endmodule
